ex2_stage: RTL and testbench

Second execute stage of the 16-bit pipeline, directly downstream of EX1. It registers EX1 results into the EX1/EX2 pipeline register and resolves conditional branches, issuing the PC redirect and bubbling the wrong-path instruction. It runs an iterative 16-cycle multiplier that stalls the front of the pipe, and drives the EX2 forwarding value back to EX1 as well as the operands for the MEM stage.

---
 rtl/ex2_stage_pkg.sv | 21 ++
 rtl/ex2_stage_mul_iter.sv | 60 ++++++
 rtl/ex2_stage.sv | 136 +++++++++++++
 tb/tb_ex2_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex2_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex2_stage_pkg : shared constants for the EX2 stage and its multiplier
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ex2_stage_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 4;

   localparam int MUL_ITERS = 16;
   localparam int CNT_W     = $clog2(MUL_ITERS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ex2_stage_mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter : radix-2 shift-add multiplier, MUL_ITERS steps, truncated product
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mul_iter
   import ex2_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_done,
   output logic [DATA_W-1:0] o_product
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MUL_ITERS - 1);

   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_run;
   logic [DATA_W-1:0] w_sum;

   assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == C_LAST) r_run <= 1'b0;
      end
   end

   // The final step's sum is presented combinationally so the caller can latch it on done.
   assign o_done    = r_run & (r_cnt == C_LAST);
   assign o_product = w_sum;

endmodule

`default_nettype wire

// File: rtl/ex2_stage.sv
// ---------------------------------------------------------------------------
// ex2_stage : EX1/EX2 pipeline register, branch resolution, iterative MUL
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ex2_stage
   import ex2_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              ex1_valid,
   input  logic [DATA_W-1:0] ex1_alu_result,
   input  logic              ex1_zero,
   input  logic [DATA_W-1:0] ex1_branch_target,
   input  logic [REG_AW-1:0] ex1_rd,
   input  logic              ex1_reg_write,
   input  logic              ex1_is_branch,
   input  logic              ex1_branch_ne,
   input  logic              ex1_is_mul,
   input  logic [DATA_W-1:0] ex1_op_a,
   input  logic [DATA_W-1:0] ex1_op_b,
   input  logic              ex1_mem_read,
   input  logic              ex1_mem_write,
   input  logic [DATA_W-1:0] ex1_store_data,
   output logic              ex2_valid,
   output logic [DATA_W-1:0] ex2_alu_result,
   output logic              ex2_fwd_valid,
   output logic [REG_AW-1:0] ex2_rd,
   output logic              ex2_reg_write,
   output logic              ex2_mem_read,
   output logic              ex2_mem_write,
   output logic [DATA_W-1:0] ex2_store_data,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target_out,
   output logic              busy
);

   logic              r_valid, r_zero, r_rw, r_is_br, r_br_ne, r_is_mul, r_mr, r_mw;
   logic [DATA_W-1:0] r_alu, r_target, r_op_a, r_op_b, r_sd, r_product;
   logic [REG_AW-1:0] r_rd;
   logic [1:0]        r_state;

   logic              w_advance, w_cond, w_taken, w_start, w_mul_done;
   logic [DATA_W-1:0] w_mul_prod;

   assign w_start   = (r_state == S_IDLE) & r_valid & r_is_mul;
   assign busy      = w_start | (r_state == S_MUL);
   assign w_advance = ~stall_in & ~busy;
   assign w_cond    = r_br_ne ? ~r_zero : r_zero;
   assign w_taken   = r_valid & r_is_br & w_cond & ~stall_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_alu    <= '0;
         r_zero   <= 1'b0;
         r_target <= '0;
         r_rd     <= '0;
         r_rw     <= 1'b0;
         r_is_br  <= 1'b0;
         r_br_ne  <= 1'b0;
         r_is_mul <= 1'b0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_mr     <= 1'b0;
         r_mw     <= 1'b0;
         r_sd     <= '0;
      end else if (w_advance) begin
         // A taken branch squashes the wrong-path instruction entering behind it.
         r_valid  <= ex1_valid & ~w_taken;
         r_rw     <= ex1_reg_write & ~w_taken;
         r_mr     <= ex1_mem_read & ~w_taken;
         r_mw     <= ex1_mem_write & ~w_taken;
         r_alu    <= ex1_alu_result;
         r_zero   <= ex1_zero;
         r_target <= ex1_branch_target;
         r_rd     <= ex1_rd;
         r_is_br  <= ex1_is_branch;
         r_br_ne  <= ex1_branch_ne;
         r_is_mul <= ex1_is_mul;
         r_op_a   <= ex1_op_a;
         r_op_b   <= ex1_op_b;
         r_sd     <= ex1_store_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) r_state <= S_MUL;
            S_MUL: begin
               if (w_mul_done) begin
                  r_state   <= S_DONE;
                  r_product <= w_mul_prod;
               end
            end
            S_DONE: if (w_advance) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   mul_iter #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_a       (r_op_a),
      .i_b       (r_op_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   assign ex2_valid         = r_valid;
   assign ex2_alu_result    = (r_state == S_DONE) ? r_product : r_alu;
   assign ex2_fwd_valid     = r_valid & r_rw & ~busy;
   assign ex2_rd            = r_rd;
   assign ex2_reg_write     = r_rw;
   assign ex2_mem_read      = r_mr;
   assign ex2_mem_write     = r_mw;
   assign ex2_store_data    = r_sd;
   assign branch_taken      = w_taken;
   assign branch_target_out = r_target;

endmodule

`default_nettype wire

// File: tb/tb_ex2_stage.sv
// ---------------------------------------------------------------------------
// tb_ex2_stage : directed self-checking bench for ex2_stage
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex2_stage;

   logic        clk = 1'b0;
   logic        rst, stall_in;
   logic        ex1_valid, ex1_zero, ex1_reg_write, ex1_is_branch, ex1_branch_ne;
   logic        ex1_is_mul, ex1_mem_read, ex1_mem_write;
   logic [15:0] ex1_alu_result, ex1_branch_target, ex1_op_a, ex1_op_b, ex1_store_data;
   logic [3:0]  ex1_rd;
   logic        ex2_valid, ex2_fwd_valid, ex2_reg_write, ex2_mem_read, ex2_mem_write;
   logic        branch_taken, busy;
   logic [15:0] ex2_alu_result, ex2_store_data, branch_target_out;
   logic [3:0]  ex2_rd;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex2_stage u_dut (
      .clk               (clk),
      .rst               (rst),
      .stall_in          (stall_in),
      .ex1_valid         (ex1_valid),
      .ex1_alu_result    (ex1_alu_result),
      .ex1_zero          (ex1_zero),
      .ex1_branch_target (ex1_branch_target),
      .ex1_rd            (ex1_rd),
      .ex1_reg_write     (ex1_reg_write),
      .ex1_is_branch     (ex1_is_branch),
      .ex1_branch_ne     (ex1_branch_ne),
      .ex1_is_mul        (ex1_is_mul),
      .ex1_op_a          (ex1_op_a),
      .ex1_op_b          (ex1_op_b),
      .ex1_mem_read      (ex1_mem_read),
      .ex1_mem_write     (ex1_mem_write),
      .ex1_store_data    (ex1_store_data),
      .ex2_valid         (ex2_valid),
      .ex2_alu_result    (ex2_alu_result),
      .ex2_fwd_valid     (ex2_fwd_valid),
      .ex2_rd            (ex2_rd),
      .ex2_reg_write     (ex2_reg_write),
      .ex2_mem_read      (ex2_mem_read),
      .ex2_mem_write     (ex2_mem_write),
      .ex2_store_data    (ex2_store_data),
      .branch_taken      (branch_taken),
      .branch_target_out (branch_target_out),
      .busy              (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ex1();
      ex1_valid = 0; ex1_zero = 0; ex1_reg_write = 0; ex1_is_branch = 0;
      ex1_branch_ne = 0; ex1_is_mul = 0; ex1_mem_read = 0; ex1_mem_write = 0;
      ex1_alu_result = 0; ex1_branch_target = 0; ex1_op_a = 0; ex1_op_b = 0;
      ex1_store_data = 0; ex1_rd = 0;
   endtask

   task automatic drv_add(input logic [15:0] res, input logic [3:0] rd);
      clr_ex1();
      ex1_valid = 1; ex1_alu_result = res; ex1_rd = rd; ex1_reg_write = 1;
   endtask

   task automatic drv_br(input logic ne, input logic zero, input logic [15:0] tgt);
      clr_ex1();
      ex1_valid = 1; ex1_is_branch = 1; ex1_branch_ne = ne; ex1_zero = zero;
      ex1_branch_target = tgt;
   endtask

   task automatic drv_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
      clr_ex1();
      ex1_valid = 1; ex1_is_mul = 1; ex1_op_a = a; ex1_op_b = b; ex1_rd = rd;
      ex1_reg_write = 1; ex1_alu_result = 16'hDEAD;
   endtask

   // Runs one MUL with a follow-on ADD held in EX1; optionally stalls in DONE.
   task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input int done_stall);
      int n_busy;
      drv_mul(a, b, 4'd2);
      tick();
      drv_add(16'h0ABC, 4'd4);
      #1;
      chk({tag, "_fwd_while_busy"}, ex2_fwd_valid, 0);
      n_busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         n_busy++;
         tick();
      end
      chk({tag, "_busy_cycles"}, n_busy, 17);
      chk({tag, "_product"}, ex2_alu_result, exp);
      chk({tag, "_fwd_done"}, ex2_fwd_valid, 1);
      if (done_stall > 0) begin
         stall_in = 1;
         for (int i = 0; i < done_stall; i++) tick();
         chk({tag, "_product_held"}, ex2_alu_result, exp);
         stall_in = 0;
         #1;
      end
      tick();
      clr_ex1();
      #1;
      chk({tag, "_next_result"}, ex2_alu_result, 16'h0ABC);
      chk({tag, "_next_rd"}, ex2_rd, 4);
   endtask

   initial begin
      rst = 1; stall_in = 0;
      clr_ex1();
      tick(); tick();
      chk("rst_valid", ex2_valid, 0);
      chk("rst_result", ex2_alu_result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_taken", branch_taken, 0);
      chk("rst_target", branch_target_out, 0);
      rst = 0;

      // ADD forwarding
      drv_add(16'h1234, 4'd3);
      tick();
      clr_ex1();
      #1;
      chk("add_result", ex2_alu_result, 16'h1234);
      chk("add_rd", ex2_rd, 3);
      chk("add_fwd", ex2_fwd_valid, 1);

      // BEQ taken, following instruction bubbled
      drv_br(1'b0, 1'b1, 16'h0040);
      tick();
      drv_add(16'h5555, 4'd5);
      #1;
      chk("beq_taken", branch_taken, 1);
      chk("beq_target", branch_target_out, 16'h0040);
      tick();
      clr_ex1();
      #1;
      chk("beq_bubble_valid", ex2_valid, 0);
      chk("beq_bubble_rw", ex2_reg_write, 0);
      chk("beq_single_pulse", branch_taken, 0);

      // BNE not taken
      drv_br(1'b1, 1'b1, 16'h0080);
      tick();
      drv_add(16'h0777, 4'd7);
      #1;
      chk("bne_not_taken", branch_taken, 0);
      tick();
      clr_ex1();
      #1;
      chk("bne_next_valid", ex2_valid, 1);
      chk("bne_next_result", ex2_alu_result, 16'h0777);

      do_mul("mul1", 16'h0123, 16'h0010, 16'h1230, 0);
      do_mul("mul_wrap", 16'hFFFF, 16'h0002, 16'hFFFE, 2);

      // Taken BNE held by a 3-cycle stall
      drv_br(1'b1, 1'b0, 16'h0100);
      tick();
      stall_in = 1;
      drv_add(16'h1111, 4'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_no_taken", branch_taken, 0);
         tick();
      end
      stall_in = 0;
      #1;
      chk("stall_release_taken", branch_taken, 1);
      chk("stall_release_target", branch_target_out, 16'h0100);
      tick();
      clr_ex1();
      #1;
      chk("stall_bubble", ex2_valid, 0);
      chk("stall_single_pulse", branch_taken, 0);

      // Reset during multiply at cnt=7
      drv_mul(16'h0003, 16'h0005, 4'd9);
      tick();
      clr_ex1();
      for (int i = 0; i < 8; i++) tick();
      chk("pre_rst_busy", busy, 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_valid", ex2_valid, 0);
      chk("mrst_result", ex2_alu_result, 0);
      chk("mrst_rd", ex2_rd, 0);
      chk("mrst_fwd", ex2_fwd_valid, 0);
      drv_add(16'h2468, 4'd6);
      tick();
      clr_ex1();
      #1;
      chk("post_rst_result", ex2_alu_result, 16'h2468);
      chk("post_rst_fwd", ex2_fwd_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
